// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Purpose:
//   Memory controller that sits between the reorder buffer's data port, the
//   instruction-fetch stage, and a byte-wide, synchronous-read RAM/IO bus.
//   Each data or fetch request is serialised into 1, 2 or 4 single-byte bus
//   cycles. The served requester gets a one-cycle completion pulse.
//   Data writes take priority over data reads, and data reads take priority
//   over fetches. A one-cycle COOLDOWN after every completion lets a level
//   request drop before the arbiter looks at it again.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   rdy            in   global enable; low freezes every register
//   rn / wn        in   data read / write request (level, held until done)
//   addr           in   data byte address
//   wvalue         in   store data, little-endian, low bytes used
//   width          in   0 = byte, 1 = half, 2/3 = word
//   sext           in   sign-extend byte/half loads
//   mem_success    out  one-cycle data completion pulse
//   read_value     out  extended load result, valid with mem_success
//   if_req         in   fetch request (level)
//   if_addr        in   fetch word address
//   if_flush       in   abort a pending or in-flight fetch
//   if_done        out  one-cycle fetch completion pulse
//   if_inst        out  fetched instruction, valid with if_done
//   mem_din        in   RAM read byte, valid one cycle after its address
//   mem_dout       out  RAM write byte
//   mem_a          out  RAM byte address
//   mem_wr         out  RAM write strobe
//   io_buffer_full in   IO write buffer full; stalls IO-region writes
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int          ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    // Data port from the reorder buffer
    input  logic              rn,
    input  logic              wn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wvalue,
    input  logic [1:0]        width,
    input  logic              sext,
    output logic              mem_success,
    output logic [31:0]       read_value,
    // Instruction-fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    // RAM / IO bus
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_D_READ   = 3'd1;
    localparam logic [2:0] ST_D_WRITE  = 3'd2;
    localparam logic [2:0] ST_I_READ   = 3'd3;
    localparam logic [2:0] ST_COOLDOWN = 3'd4;

    // Map the access-size code onto a byte count. Code 3 is treated as a word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] w);
        case (w)
            2'd0:    size_to_bytes = 3'd1;
            2'd1:    size_to_bytes = 3'd2;
            default: size_to_bytes = 3'd4;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;       // latched start address of the access
    logic [31:0]       r_wdata;      // latched store data
    logic [1:0]        r_width;      // latched size code (drives extension)
    logic              r_sext;       // latched sign-extend flag
    logic [2:0]        r_nbytes;     // bytes in this access (1, 2 or 4)
    logic [2:0]        r_cnt;        // edges since accept (reads) / bytes done (writes)
    logic [31:0]       r_buf;        // read bytes gathered so far
    logic              r_wr;         // write phase active (before stall/rdy gating)
    logic              r_success;
    logic              r_if_done;
    logic [31:0]       r_read_value;
    logic [31:0]       r_if_inst;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [2:0]  w_cnt_inc;
    logic [1:0]  w_idx;
    logic [31:0] w_assembled;
    logic [31:0] w_extended;
    logic        w_io_stall;

    assign w_cnt_inc = r_cnt + 3'd1;

    // The byte on mem_din belongs to the address issued two edges earlier.
    // That puts it at position r_cnt-1 of the result.
    assign w_idx = r_cnt[1:0] - 2'd1;

    // An IO-region write with a full buffer neither strobes nor advances.
    // The same byte is presented again every cycle until the buffer drains.
    assign w_io_stall = (r_state == ST_D_WRITE) && r_wr &&
                        (r_mem_a[17:16] == IO_HI) && io_buffer_full;

    // The final read edge folds the byte still on mem_din into the result.
    // The complete value can then be registered in the same cycle.
    // NOTE: every signal assigned in always_comb gets a default first.
    // A path that skips the assignment would otherwise infer a latch.
    always_comb begin
        w_assembled = r_buf;
        w_assembled[{w_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        w_extended = w_assembled;
        case (r_width)
            2'd0:    w_extended = {{24{r_sext & w_assembled[7]}},  w_assembled[7:0]};
            2'd1:    w_extended = {{16{r_sext & w_assembled[15]}}, w_assembled[15:0]};
            default: w_extended = w_assembled;
        endcase
    end

    // -------------------------------------------------------------------------
    // Main sequential process
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only.
    // All registers then update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_wdata      <= '0;
            r_width      <= '0;
            r_sext       <= 1'b0;
            r_nbytes     <= '0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_wr         <= 1'b0;
            r_success    <= 1'b0;
            r_if_done    <= 1'b0;
            r_read_value <= '0;
            r_if_inst    <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
        end else if (rdy) begin
            // Completion strobes are single-cycle unless set again below.
            r_success <= 1'b0;
            r_if_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (wn) begin
                        // Write wins over a simultaneous read. rn stays pending.
                        r_state    <= ST_D_WRITE;
                        r_base     <= addr;
                        r_wdata    <= wvalue;
                        r_width    <= width;
                        r_sext     <= sext;
                        r_nbytes   <= size_to_bytes(width);
                        r_cnt      <= '0;
                        r_mem_a    <= addr;
                        r_mem_dout <= wvalue[7:0];
                        r_wr       <= 1'b1;
                    end else if (rn) begin
                        r_state  <= ST_D_READ;
                        r_base   <= addr;
                        r_width  <= width;
                        r_sext   <= sext;
                        r_nbytes <= size_to_bytes(width);
                        r_cnt    <= '0;
                        r_buf    <= '0;
                        r_mem_a  <= addr;
                    end else if (if_req && !if_flush) begin
                        r_state  <= ST_I_READ;
                        r_base   <= if_addr;
                        r_width  <= 2'd2;
                        r_sext   <= 1'b0;
                        r_nbytes <= 3'd4;
                        r_cnt    <= '0;
                        r_buf    <= '0;
                        r_mem_a  <= if_addr;
                    end
                end

                ST_D_READ, ST_I_READ: begin
                    if (r_state == ST_I_READ && if_flush) begin
                        // Drop the fetch. No strobe, and if_inst keeps its old value.
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_buf[{w_idx, 3'b000} +: 8] <= mem_din;
                        end
                        if (r_cnt == r_nbytes) begin
                            // The last byte arrives on this edge.
                            r_state <= ST_COOLDOWN;
                            if (r_state == ST_D_READ) begin
                                r_read_value <= w_extended;
                                r_success    <= 1'b1;
                            end else begin
                                r_if_inst <= w_assembled;
                                r_if_done <= 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                            // Issue the next address while bytes remain.
                            // The last address is held while its data returns.
                            if (w_cnt_inc < r_nbytes) begin
                                r_mem_a <= r_base + ADDR_W'(w_cnt_inc);
                            end
                        end
                    end
                end

                ST_D_WRITE: begin
                    if (!w_io_stall) begin
                        if (w_cnt_inc == r_nbytes) begin
                            r_wr      <= 1'b0;
                            r_success <= 1'b1;
                            r_state   <= ST_COOLDOWN;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_mem_a    <= r_base + ADDR_W'(w_cnt_inc);
                            r_mem_dout <= r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
                        end
                    end
                end

                ST_COOLDOWN: begin
                    // Requests are ignored here, so a level request is served once.
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The strobe is gated combinationally. A frozen or stalled cycle never writes.
    assign mem_wr      = r_wr && rdy && !w_io_stall;
    assign mem_a       = r_mem_a;
    assign mem_dout    = r_mem_dout;
    assign mem_success = r_success;
    assign read_value  = r_read_value;
    assign if_done     = r_if_done;
    assign if_inst     = r_if_inst;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//
// Directed testbench for mem_ctrl. A small synchronous-read RAM model drives
// mem_din. Bus writes are recorded in a shadow array with per-byte flags.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rn, wn;
    logic [31:0] addr, wvalue;
    logic [1:0]  width;
    logic        sext;
    logic        mem_success;
    logic [31:0] read_value;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_checks = 0;
    int n_errors = 0;

    // Preloaded read contents (written only by the stimulus process)
    logic [7:0] ram [0:4095];
    // Record of bus writes (written only by the bus model)
    bit   [7:0] wmem  [0:4095];
    bit         wflag [0:4095];
    int         wr_count = 0;
    int         io_wr_count = 0;

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rn             (rn),
        .wn             (wn),
        .addr           (addr),
        .wvalue         (wvalue),
        .width          (width),
        .sext           (sext),
        .mem_success    (mem_success),
        .read_value     (read_value),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_done        (if_done),
        .if_inst        (if_inst),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM and write recorder
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            wmem[mem_a[11:0]]  <= mem_dout;
            wflag[mem_a[11:0]] <= 1'b1;
            wr_count           <= wr_count + 1;
            if (mem_a[17:16] == 2'b11) io_wr_count <= io_wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int wc0;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        ram[12'h200] = 8'h80;
        ram[12'h400] = 8'h13; ram[12'h401] = 8'h05; ram[12'h402] = 8'h00; ram[12'h403] = 8'h00;
        ram[12'h500] = 8'hEF; ram[12'h501] = 8'hBE; ram[12'h502] = 8'hAD; ram[12'h503] = 8'hDE;
        ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h82;

        rst = 1'b1; rdy = 1'b1; rn = 1'b0; wn = 1'b0; addr = '0; wvalue = '0;
        width = 2'd0; sext = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        io_buffer_full = 1'b0;
        step(); step();
        rst = 1'b0;

        // ---- Reset state ----
        check("rst_success", {31'd0, mem_success}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_mem_wr",  {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a",   mem_a, 32'd0);
        check("rst_dout",    {24'd0, mem_dout}, 32'd0);
        check("rst_rv",      read_value, 32'd0);
        check("rst_inst",    if_inst, 32'd0);

        // ---- 1. Word read at 0x100 ----
        rn = 1'b1; addr = 32'h100; width = 2'd2; sext = 1'b0;
        step(); check("w_rd_a0", mem_a, 32'h100);
        step(); check("w_rd_a1", mem_a, 32'h101);
        step(); check("w_rd_a2", mem_a, 32'h102);
        step(); check("w_rd_a3", mem_a, 32'h103);
        step(); check("w_rd_e4_nopulse", {31'd0, mem_success}, 32'd0);
        step(); check("w_rd_e5_pulse", {31'd0, mem_success}, 32'd1);
                check("w_rd_value", read_value, 32'h12345678);
        rn = 1'b0;
        step(); check("w_rd_cooldown_drop", {31'd0, mem_success}, 32'd0);

        // ---- 2. Byte read at 0x200, sign- and zero-extended ----
        rn = 1'b1; addr = 32'h200; width = 2'd0; sext = 1'b1;
        step(); check("b_rd_a0", mem_a, 32'h200);
        step(); check("b_rd_e1_nopulse", {31'd0, mem_success}, 32'd0);
        step(); check("b_rd_e2_pulse", {31'd0, mem_success}, 32'd1);
                check("b_rd_sext", read_value, 32'hFFFFFF80);
        rn = 1'b0;
        step();
        rn = 1'b1; sext = 1'b0;
        step(); step();
        step(); check("b_rd_zext_pulse", {31'd0, mem_success}, 32'd1);
                check("b_rd_zext", read_value, 32'h00000080);
        rn = 1'b0;
        step();

        // ---- Half read wrapping past 0xFFFFFFFF, sign-extended ----
        rn = 1'b1; addr = 32'hFFFF_FFFF; width = 2'd1; sext = 1'b1;
        step(); check("wrap_a0", mem_a, 32'hFFFF_FFFF);
        step(); check("wrap_a1", mem_a, 32'h0000_0000);
        step(); check("wrap_e2_nopulse", {31'd0, mem_success}, 32'd0);
        step(); check("wrap_e3_pulse", {31'd0, mem_success}, 32'd1);
                check("wrap_value", read_value, 32'hFFFF8234);
        rn = 1'b0;
        step();

        // ---- 3. Half write at 0x300 ----
        wc0 = wr_count;
        wn = 1'b1; addr = 32'h300; wvalue = 32'hAABBCCDD; width = 2'd1;
        step(); check("h_wr_e0_wr", {31'd0, mem_wr}, 32'd1);
                check("h_wr_e0_a", mem_a, 32'h300);
                check("h_wr_e0_d", {24'd0, mem_dout}, 32'hDD);
        step(); check("h_wr_e1_wr", {31'd0, mem_wr}, 32'd1);
                check("h_wr_e1_a", mem_a, 32'h301);
                check("h_wr_e1_d", {24'd0, mem_dout}, 32'hCC);
                check("h_wr_e1_nopulse", {31'd0, mem_success}, 32'd0);
        step(); check("h_wr_e2_wr", {31'd0, mem_wr}, 32'd0);
                check("h_wr_e2_pulse", {31'd0, mem_success}, 32'd1);
        wn = 1'b0;
        step();
        check("h_wr_count", wr_count - wc0, 32'd2);
        check("h_wr_b0", {24'd0, wmem[12'h300]}, 32'hDD);
        check("h_wr_b1", {24'd0, wmem[12'h301]}, 32'hCC);
        check("h_wr_302_untouched", {31'd0, wflag[12'h302]}, 32'd0);

        // ---- 4. IO write stalled by a full buffer for three cycles ----
        wn = 1'b1; addr = 32'h0003_0000; wvalue = 32'h0000005A; width = 2'd0;
        io_buffer_full = 1'b1;
        step(); check("io_stall1_wr", {31'd0, mem_wr}, 32'd0);
                check("io_stall_a", mem_a, 32'h0003_0000);
        step(); check("io_stall2_wr", {31'd0, mem_wr}, 32'd0);
        step(); check("io_stall3_wr", {31'd0, mem_wr}, 32'd0);
                check("io_stall3_nopulse", {31'd0, mem_success}, 32'd0);
        io_buffer_full = 1'b0;
        #1;     check("io_free_wr", {31'd0, mem_wr}, 32'd1);
                check("io_free_d", {24'd0, mem_dout}, 32'h5A);
        step(); check("io_done_pulse", {31'd0, mem_success}, 32'd1);
                check("io_done_wr", {31'd0, mem_wr}, 32'd0);
        wn = 1'b0;
        step();
        check("io_wr_count", io_wr_count, 32'd1);

        // ---- 5. Data read and fetch requested together ----
        rn = 1'b1; addr = 32'h100; width = 2'd2; sext = 1'b0;
        if_req = 1'b1; if_addr = 32'h400;
        step(); check("arb_data_first", mem_a, 32'h100);
        step(); step(); step(); step();
        step(); check("arb_rd_pulse", {31'd0, mem_success}, 32'd1);
                check("arb_rd_value", read_value, 32'h12345678);
                check("arb_no_ifdone", {31'd0, if_done}, 32'd0);
        // rn is still high through COOLDOWN and drops after it.
        step(); check("arb_cooldown", {31'd0, mem_success}, 32'd0);
        rn = 1'b0;
        step(); check("arb_fetch_start", mem_a, 32'h400);
        step(); step(); step(); step();
        step(); check("arb_if_done", {31'd0, if_done}, 32'd1);
                check("arb_if_inst", if_inst, 32'h00000513);
                check("arb_no_rd_repeat", {31'd0, mem_success}, 32'd0);
        if_req = 1'b0;
        step();

        // ---- 6. Fetch flushed after two bytes ----
        if_req = 1'b1; if_addr = 32'h500;
        step(); check("fl_a0", mem_a, 32'h500);
        step(); step(); step();
        if_flush = 1'b1; if_req = 1'b0;
        step(); check("fl_no_done", {31'd0, if_done}, 32'd0);
                check("fl_inst_kept", if_inst, 32'h00000513);
        if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h400;
        step(); check("fl_new_accept", mem_a, 32'h400);
        step(); step(); step(); step();
        step(); check("fl_new_done", {31'd0, if_done}, 32'd1);
                check("fl_new_inst", if_inst, 32'h00000513);
        if_req = 1'b0;
        step();

        // ---- Flush in IDLE blocks a same-cycle fetch ----
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h600;
        step(); check("idle_flush_block", mem_a, 32'h403);
        if_flush = 1'b0;
        step(); check("idle_flush_release", mem_a, 32'h600);
        step();
        // Reset during a fetch abandons it and clears the outputs.
        rst = 1'b1; if_req = 1'b0;
        step(); check("mid_rst_a", mem_a, 32'd0);
                check("mid_rst_inst", if_inst, 32'd0);
                check("mid_rst_done", {31'd0, if_done}, 32'd0);
        rst = 1'b0;

        // ---- Reset during a word write stops further writes ----
        wn = 1'b1; addr = 32'h700; wvalue = 32'h01020304; width = 2'd2;
        step(); check("rw_b0_d", {24'd0, mem_dout}, 32'h04);
        step(); check("rw_b1_a", mem_a, 32'h701);
        rst = 1'b1;
        step(); check("rw_rst_wr", {31'd0, mem_wr}, 32'd0);
        rst = 1'b0; wn = 1'b0;
        step(); step();
        check("rw_701_written", {24'd0, wmem[12'h701]}, 32'h03);
        check("rw_702_untouched", {31'd0, wflag[12'h702]}, 32'd0);

        // ---- rdy low freezes the block and masks mem_wr ----
        wc0 = wr_count;
        wn = 1'b1; addr = 32'h800; wvalue = 32'h77; width = 2'd0;
        step(); check("rdy_wr_on", {31'd0, mem_wr}, 32'd1);
        rdy = 1'b0;
        #1;     check("rdy_wr_masked", {31'd0, mem_wr}, 32'd0);
        step(); step();
                check("rdy_hold_a", mem_a, 32'h800);
                check("rdy_hold_nopulse", {31'd0, mem_success}, 32'd0);
        rdy = 1'b1;
        #1;     check("rdy_wr_back", {31'd0, mem_wr}, 32'd1);
        step(); check("rdy_done_pulse", {31'd0, mem_success}, 32'd1);
        wn = 1'b0;
        step();
        check("rdy_one_write", wr_count - wc0, 32'd1);
        check("rdy_data", {24'd0, wmem[12'h800]}, 32'h77);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
